// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding, byte width
// and a small one-hot to index helper.
package uart_arb_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOCK = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  // Encodes a one-hot vector of up to 8 requesters into an index.
  function automatic logic [2:0] oh_idx(input logic [7:0] oh);
    oh_idx = 3'd0;
    for (int k = 0; k < 8; k++) begin
      if (oh[k]) oh_idx = 3'(k);
    end
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request strictly after ptr,
// wrapping around to bit 0.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic          valid
);

  localparam logic [N-1:0] ONE = N'(1);

  logic [N-1:0] mask_hi;
  logic [N-1:0] req_hi;
  logic [N-1:0] pick_hi;
  logic [N-1:0] pick_lo;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_mask
      assign mask_hi[gi] = (gi > int'(ptr));
    end
  endgenerate

  // Lowest set bit of the upper window wins; otherwise wrap to the lowest overall.
  assign req_hi  = req & mask_hi;
  assign pick_hi = req_hi & (~req_hi + ONE);
  assign pick_lo = req & (~req + ONE);
  assign pick    = (|req_hi) ? pick_hi : pick_lo;
  assign valid   = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among N byte streams with round-robin arbitration,
// packet locking until a LAST byte, and forced release after an idle timeout.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N       = 4,
  parameter int Timeout = 1023
) (
  input  logic                CLK,
  input  logic                RSTN,
  input  logic [N-1:0]        REQ,
  input  logic [BYTE_W*N-1:0] DIN,
  input  logic [N-1:0]        LAST,
  output logic [N-1:0]        ACK,
  output logic [N-1:0]        GRANT,
  input  logic                UART_RDY,
  output logic                UART_WE,
  output logic [BYTE_W-1:0]   UART_DIN,
  output logic                TIMEOUT
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(Timeout + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(Timeout - 1);

  state_t              state_reg, state_next;
  logic [N-1:0]        grant_reg, grant_next;
  logic [PW-1:0]       owner_reg, owner_next;
  logic [PW-1:0]       ptr_reg, ptr_next;
  logic [CW-1:0]       cnt_reg, cnt_next;
  logic                last_flag_reg, last_flag_next;
  logic [N-1:0]        ack_reg, ack_next;
  logic                we_reg, we_next;
  logic [BYTE_W-1:0]   udin_reg, udin_next;
  logic                tmo_reg, tmo_next;

  logic [N-1:0]        pick;
  logic                pick_valid;
  logic [PW-1:0]       pick_idx;
  logic [BYTE_W-1:0]   din_arr [N];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_din
      assign din_arr[gi] = DIN[gi*BYTE_W +: BYTE_W];
    end
  endgenerate

  rr_pick #(.N(N), .PW(PW)) u_pick (
    .req   (REQ),
    .ptr   (ptr_reg),
    .pick  (pick),
    .valid (pick_valid)
  );

  assign pick_idx = PW'(oh_idx(8'(pick)));

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_reg     <= S_IDLE;
      grant_reg     <= '0;
      owner_reg     <= '0;
      ptr_reg       <= PW'(N - 1);
      cnt_reg       <= '0;
      last_flag_reg <= 1'b0;
      ack_reg       <= '0;
      we_reg        <= 1'b0;
      udin_reg      <= '0;
      tmo_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      grant_reg     <= grant_next;
      owner_reg     <= owner_next;
      ptr_reg       <= ptr_next;
      cnt_reg       <= cnt_next;
      last_flag_reg <= last_flag_next;
      ack_reg       <= ack_next;
      we_reg        <= we_next;
      udin_reg      <= udin_next;
      tmo_reg       <= tmo_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    grant_next     = grant_reg;
    owner_next     = owner_reg;
    ptr_next       = ptr_reg;
    cnt_next       = cnt_reg;
    last_flag_next = last_flag_reg;
    ack_next       = '0;
    we_next        = 1'b0;
    udin_next      = udin_reg;
    tmo_next       = 1'b0;

    case (state_reg)
      S_IDLE: begin
        cnt_next = '0;
        if (pick_valid) begin
          grant_next = pick;
          owner_next = pick_idx;
          state_next = S_LOCK;
        end
      end
      S_LOCK: begin
        if (REQ[owner_reg] && UART_RDY) begin
          udin_next      = din_arr[owner_reg];
          we_next        = 1'b1;
          ack_next       = grant_reg;
          cnt_next       = '0;
          last_flag_next = LAST[owner_reg];
          state_next     = S_HOLD;
        end else if (REQ[owner_reg]) begin
          // Owner is still presenting a byte; only the UART is busy.
          cnt_next = '0;
        end else if (cnt_reg >= CNT_LAST) begin
          tmo_next   = 1'b1;
          grant_next = '0;
          ptr_next   = owner_reg;
          cnt_next   = '0;
          state_next = S_IDLE;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      S_HOLD: begin
        if (last_flag_reg) begin
          grant_next = '0;
          ptr_next   = owner_reg;
          state_next = S_IDLE;
        end else begin
          state_next = S_LOCK;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign ACK      = ack_reg;
  assign GRANT    = grant_reg;
  assign UART_WE  = we_reg;
  assign UART_DIN = udin_reg;
  assign TIMEOUT  = tmo_reg;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter among N byte-stream requesters, e.g. BRAM string streamers, an echo path and a status reporter.
- Round-robin arbitration with packet locking: a granted requester keeps the UART until it sends a byte flagged LAST, or until it stalls past a timeout.
- Sits between the requesters and the UART transmit side (UART DIN/RDY) inside the SoC.

Parameters:
- N, 4, number of requesters (2..8).
- Timeout, 1023, idle cycles inside a locked packet before the grant is forcibly released (1..65535).

Ports:
- CLK  input  1  system clock, all logic on rising edge.
- RSTN  input  1  asynchronous, active-low reset.
- REQ  input  N  per-requester "byte valid" level; held until the matching ACK.
- DIN  input  8*N  per-requester byte; requester i on bits [8i+7:8i]; stable while REQ[i] high.
- LAST  input  N  per-requester end-of-packet flag, qualified with REQ[i].
- ACK  output  N  one-cycle pulse: byte of requester i captured.
- GRANT  output  N  one-hot current owner; all zero when unowned.
- UART_RDY  input  1  UART transmitter able to accept a byte.
- UART_WE  output  1  one-cycle write strobe to UART.
- UART_DIN  output  8  byte to UART, valid while UART_WE is high; held afterwards.
- TIMEOUT  output  1  one-cycle pulse when a lock is forcibly released.

Behaviour:
- Reset (async, RSTN low): state IDLE; GRANT=0, ACK=0, UART_WE=0, UART_DIN=8'h00, TIMEOUT=0; rr pointer=N-1, so requester 0 has top priority first; timeout counter=0.
- All outputs are registered.
- State IDLE:
  - If any REQ is high, pick the first high REQ searching from (ptr+1) mod N upward with wrap.
  - GRANT <= onehot(pick); go LOCK. No byte is sent in this cycle.
- State LOCK (owner g):
  - If REQ[g] && UART_RDY: UART_DIN <= DIN[g], UART_WE <= 1, ACK[g] <= 1, counter <= 0.
  - Then go HOLD, latching last_flag <= LAST[g].
  - Otherwise counter++. When counter reaches Timeout: TIMEOUT <= 1, GRANT <= 0, ptr <= g, go IDLE.
- State HOLD: exactly one cycle. It lets UART_RDY fall and lets the requester update DIN/LAST/REQ after seeing ACK.
  - If last_flag: GRANT <= 0, ptr <= g, go IDLE.
  - Else go LOCK.
- Latency: REQ[i] rising in IDLE with UART_RDY high gives GRANT at edge 1 and UART_WE/ACK at edge 2. Within a packet, throughput is at most one byte per 2 cycles, further limited by UART_RDY.
- Requester rule: after seeing ACK high, present the next byte (or drop REQ) in that same cycle. A byte is never captured twice, because HOLD blocks capture.
- UART_RDY low in LOCK: wait. Waiting cycles count toward Timeout only when REQ[g] is low. The counter is reset every cycle REQ[g] && !UART_RDY.
- REQ[g] dropping mid-packet: grant held until Timeout. REQ of non-owners is ignored while locked.
- Requests from other requesters arriving while locked are served in round-robin order after release. A released owner gets lowest priority next round.
- Single-byte packet (LAST with first byte): IDLE→LOCK→HOLD→IDLE, 3 cycles plus the UART_RDY wait.
- RSTN asserted mid-packet: immediate return to reset values. An in-flight UART_WE pulse is cut; the UART is not otherwise notified.
- Counter width: clog2(Timeout+1); saturating compare, no wrap.
- ACK and UART_WE are always coincident. GRANT is always one-hot or zero.

Decomposition:
- Shared package uart_arb_pkg: state encoding constants (S_IDLE, S_LOCK, S_HOLD) and the byte width constant (8).
- One sub-module, rr_pick: combinational N-bit round-robin priority picker. Inputs are the REQ vector and ptr; outputs are the one-hot pick and a valid flag.
- FSM, counter and datapath mux stay in uart_tx_arbiter.

Test Plan:
- Reset, single requester: REQ=0001, DIN0=8'h48, LAST0=1, UART_RDY=1 → GRANT=0001 at edge 1; UART_WE=1, UART_DIN=8'h48, ACK=0001 at edge 2; GRANT=0000 at edge 3.
- Packet lock: req0 sends "Hi" (8'h48, then 8'h69 with LAST) while REQ1 is held high from cycle 0 → UART sees 48,69 contiguously; req1 is granted only after the 69 HOLD.
- Round-robin fairness: all four REQ high, one-byte packets each, UART_RDY=1 → grant order 0,1,2,3,0; each ACK exactly once per grant.
- Backpressure: UART_RDY low for 20 cycles during req2's packet, REQ2 held → no UART_WE, no TIMEOUT, byte sent on the first cycle UART_RDY=1.
- Timeout: Timeout=8; req1 sends one non-LAST byte, then drops REQ → TIMEOUT pulse exactly 8 cycles into LOCK, GRANT=0000, then req2 (waiting) granted next.
- Async reset mid-packet: RSTN low between UART_WE pulses → GRANT, ACK, UART_WE go 0 immediately without a clock; after release, arbitration restarts from requester 0.
